// File: rtl/rr_arbiter8.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter8
// Description : Eight-requester round-robin arbiter with a registered one-hot
//               grant, an encoded grant index and a grant-hold limit.
//               The grant is held while its owner keeps requesting, for at
//               most HOLD_MAX cycles (0 = unlimited), then handed over.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter8 #(
    parameter int HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid,
    output logic       expired
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    // Value of the hold counter on the last cycle a grant may be held.
    localparam logic [7:0] c_HOLD_LAST = (HOLD_MAX == 0) ? 8'd0 : 8'(HOLD_MAX - 1);
    localparam logic       c_HOLD_ON   = (HOLD_MAX != 0);

    state_t     r_state;
    logic [2:0] r_ptr;
    logic [7:0] r_hold_cnt;
    logic [7:0] r_gnt;
    logic [2:0] r_gnt_id;
    logic       r_gnt_valid;
    logic       r_expired;

    state_t     w_state_nx;
    logic [2:0] w_ptr_nx;
    logic [7:0] w_hold_nx;
    logic [7:0] w_gnt_nx;
    logic [2:0] w_gnt_id_nx;
    logic       w_gnt_valid_nx;

    logic [2:0] w_base;
    logic [2:0] w_idx;
    logic [2:0] w_win;
    logic       w_found;
    logic       w_preempt;
    logic       w_release;

    // Preemption only applies when the owner is still asking for the grant;
    // a simultaneous voluntary drop counts as a voluntary release.
    assign w_preempt = (r_state == S_BUSY) && c_HOLD_ON && req[r_gnt_id]
                       && (r_hold_cnt == c_HOLD_LAST);
    assign w_release = (r_state == S_BUSY) && (!req[r_gnt_id] || w_preempt);

    // Round-robin search starting at the priority pointer; on a release the
    // pointer advances past the owner in the same edge, so search from there.
    always_comb begin
        w_base  = (r_state == S_BUSY) ? (r_gnt_id + 3'd1) : r_ptr;
        w_idx   = 3'd0;
        w_win   = 3'd0;
        w_found = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            w_idx = w_base + 3'(i);
            if (req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nx     = r_state;
        w_ptr_nx       = r_ptr;
        w_hold_nx      = r_hold_cnt;
        w_gnt_nx       = r_gnt;
        w_gnt_id_nx    = r_gnt_id;
        w_gnt_valid_nx = r_gnt_valid;
        case (r_state)
            S_IDLE: begin
                w_gnt_nx       = 8'h00;
                w_gnt_id_nx    = 3'd0;
                w_gnt_valid_nx = 1'b0;
                w_hold_nx      = 8'd0;
                if (en && w_found) begin
                    w_gnt_nx       = 8'h01 << w_win;
                    w_gnt_id_nx    = w_win;
                    w_gnt_valid_nx = 1'b1;
                    w_state_nx     = S_BUSY;
                end
            end
            S_BUSY: begin
                if (w_release) begin
                    w_ptr_nx  = r_gnt_id + 3'd1;
                    w_hold_nx = 8'd0;
                    if (en && w_found) begin
                        w_gnt_nx       = 8'h01 << w_win;
                        w_gnt_id_nx    = w_win;
                        w_gnt_valid_nx = 1'b1;
                    end else begin
                        w_gnt_nx       = 8'h00;
                        w_gnt_id_nx    = 3'd0;
                        w_gnt_valid_nx = 1'b0;
                        w_state_nx     = S_IDLE;
                    end
                end else if (r_hold_cnt != 8'hFF) begin
                    w_hold_nx = r_hold_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nx     = S_IDLE;
                w_gnt_nx       = 8'h00;
                w_gnt_id_nx    = 3'd0;
                w_gnt_valid_nx = 1'b0;
                w_hold_nx      = 8'd0;
            end
        endcase
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ptr       <= 3'd0;
            r_hold_cnt  <= 8'd0;
            r_gnt       <= 8'h00;
            r_gnt_id    <= 3'd0;
            r_gnt_valid <= 1'b0;
            r_expired   <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_ptr       <= w_ptr_nx;
            r_hold_cnt  <= w_hold_nx;
            r_gnt       <= w_gnt_nx;
            r_gnt_id    <= w_gnt_id_nx;
            r_gnt_valid <= w_gnt_valid_nx;
            r_expired   <= w_preempt;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_id    = r_gnt_id;
    assign gnt_valid = r_gnt_valid;
    assign expired   = r_expired;

endmodule
`default_nettype wire
